round_robin_arbiter: RTL and testbench

ROUND_ROBIN_ARBITER -- requirements
Module: round_robin_arbiter

---
 rtl/round_robin_arbiter.sv | 125 ++++++++++++
 tb/tb_round_robin_arbiter.sv | 186 ++++++++++++++++++
 2 files changed

// File: rtl/round_robin_arbiter.sv
// Round-robin (or fixed-priority) arbiter with burst locking: a grant taken on a
// non-last transfer is held until the burst's last beat is accepted.
module round_robin_arbiter #(
    parameter int WIDTH = -1,
    parameter bit FIXED = 1'b0,
    localparam int W     = (WIDTH < 1) ? 1 : WIDTH,
    localparam int IDX_W = (W > 1) ? $clog2(W) : 1
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic [W-1:0]     request,
    input  logic             last,
    input  logic             ready,
    output logic [W-1:0]     grant,
    output logic             valid,
    output logic [IDX_W-1:0] grant_idx
);

    localparam int PW = IDX_W + 1;

    typedef enum logic [0:0] {
        IDLE   = 1'b0,
        LOCKED = 1'b1
    } state_t;

    state_t           state_r;
    logic [IDX_W-1:0] ptr_r;
    logic [W-1:0]     lk_r;

    logic [W-1:0]     above_s;
    logic [W-1:0]     hi_req_s;
    logic [W-1:0]     pick_src_s;
    logic [W-1:0]     cand_s;
    logic [W-1:0]     grant_s;
    logic             valid_s;
    logic [IDX_W-1:0] idx_s;
    logic             xfer_s;

    // Mask of requester positions strictly above the last winner
    always_comb begin
        above_s = {W{1'b0}};
        for (int j = 0; j < W; j++) begin
            if (PW'(j) > {1'b0, ptr_r}) begin
                above_s[j] = 1'b1;
            end else begin
                above_s[j] = 1'b0;
            end
        end
    end

    // Candidate: lowest request above ptr, wrapping to the lowest overall
    always_comb begin
        hi_req_s = request & above_s;
        if (FIXED) begin
            pick_src_s = request;
        end else if (|hi_req_s) begin
            pick_src_s = hi_req_s;
        end else begin
            pick_src_s = request;
        end
        cand_s = pick_src_s & (~pick_src_s + W'(1'b1));
    end

    // Presented grant: the locked owner while bursting, else the live candidate
    always_comb begin
        if (state_r == LOCKED) begin
            grant_s = lk_r;
            valid_s = |(request & lk_r);
        end else begin
            grant_s = cand_s;
            valid_s = |request;
        end
        idx_s = {IDX_W{1'b0}};
        for (int j = 0; j < W; j++) begin
            if (grant_s[j]) begin
                idx_s = idx_s | IDX_W'(j);
            end else begin
                idx_s = idx_s;
            end
        end
    end

    assign xfer_s    = valid_s & ready;
    assign grant     = grant_s;
    assign valid     = valid_s;
    assign grant_idx = idx_s;

    // Lock FSM, lock owner and round-robin pointer
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_r <= IDLE;
            ptr_r   <= IDX_W'(W - 1);
            lk_r    <= {W{1'b0}};
        end else begin
            case (state_r)
                IDLE: begin
                    if (xfer_s && !last) begin
                        state_r <= LOCKED;
                        lk_r    <= grant_s;
                    end else begin
                        state_r <= IDLE;
                    end
                end
                LOCKED: begin
                    if (xfer_s && last) begin
                        state_r <= IDLE;
                    end else begin
                        state_r <= LOCKED;
                    end
                end
                default: begin
                    state_r <= IDLE;
                    lk_r    <= {W{1'b0}};
                end
            endcase
            // Only a completed burst moves the rotation point
            if (xfer_s && last && !FIXED) begin
                ptr_r <= idx_s;
            end else begin
                ptr_r <= ptr_r;
            end
        end
    end

endmodule

// File: tb/tb_round_robin_arbiter.sv
// Directed-vector and model-based bench for round_robin_arbiter
// (WIDTH=4 round-robin, WIDTH=4 fixed-priority, WIDTH=3 stress).
module tb_round_robin_arbiter;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Instance A: WIDTH=4 round-robin
    logic       rstn_a, rdy_a, lst_a, valid_a;
    logic [3:0] req_a, grant_a;
    logic [1:0] idx_a;
    round_robin_arbiter #(.WIDTH(4), .FIXED(0)) dut_a (
        .clk(clk), .rstn(rstn_a), .request(req_a), .last(lst_a), .ready(rdy_a),
        .grant(grant_a), .valid(valid_a), .grant_idx(idx_a));

    // Instance B: WIDTH=4 fixed priority
    logic       rstn_b, rdy_b, lst_b, valid_b;
    logic [3:0] req_b, grant_b;
    logic [1:0] idx_b;
    round_robin_arbiter #(.WIDTH(4), .FIXED(1)) dut_b (
        .clk(clk), .rstn(rstn_b), .request(req_b), .last(lst_b), .ready(rdy_b),
        .grant(grant_b), .valid(valid_b), .grant_idx(idx_b));

    // Instance C: WIDTH=3 round-robin
    logic       rstn_c, rdy_c, lst_c, valid_c;
    logic [2:0] req_c, grant_c;
    logic [1:0] idx_c;
    round_robin_arbiter #(.WIDTH(3), .FIXED(0)) dut_c (
        .clk(clk), .rstn(rstn_c), .request(req_c), .last(lst_c), .ready(rdy_c),
        .grant(grant_c), .valid(valid_c), .grant_idx(idx_c));

    typedef struct {
        logic       rst;
        logic [3:0] req;
        logic       rdy;
        logic       lst;
        logic [3:0] g;
        logic       v;
        logic       ci;
        logic [1:0] idx;
    } vec_t;

    vec_t vecs[$];

    task automatic check(input string name, input logic [3:0] ag, input logic [3:0] eg,
                         input logic av, input logic ev, input logic [1:0] ai,
                         input logic [1:0] ei, input logic ci);
        checks++;
        if (ag !== eg || av !== ev || (ci && ai !== ei)) begin
            errors++;
            $display("FAIL %s: grant=%b valid=%b idx=%0d, required grant=%b valid=%b idx=%0d",
                     name, ag, av, ai, eg, ev, ei);
        end
    endtask

    task automatic step_b(input string name, input logic [3:0] r, input logic rd, input logic l,
                          input logic [3:0] eg, input logic ev, input logic ci, input logic [1:0] ei);
        req_b = r; rdy_b = rd; lst_b = l;
        #1;
        check(name, grant_b, eg, valid_b, ev, idx_b, ei, ci);
        @(negedge clk);
    endtask

    initial begin
        logic [2:0] eg;
        logic       ev;
        int         ei, m_ptr, m_lk, j;
        bit         m_locked;

        rstn_a = 1'b0; rstn_b = 1'b0; rstn_c = 1'b0;
        req_a = 4'b0; req_b = 4'b0; req_c = 3'b0;
        rdy_a = 1'b0; rdy_b = 1'b0; rdy_c = 1'b0;
        lst_a = 1'b0; lst_b = 1'b0; lst_c = 1'b0;

        //            rst   req      rdy   lst   grant    v     ci    idx
        vecs.push_back('{1'b1, 4'b0000, 1'b0, 1'b0, 4'b0000, 1'b0, 1'b1, 2'd0});
        vecs.push_back('{1'b0, 4'b1010, 1'b1, 1'b1, 4'b0010, 1'b1, 1'b1, 2'd1});
        vecs.push_back('{1'b0, 4'b1010, 1'b1, 1'b1, 4'b1000, 1'b1, 1'b1, 2'd3});
        vecs.push_back('{1'b0, 4'b1010, 1'b1, 1'b1, 4'b0010, 1'b1, 1'b1, 2'd1});
        vecs.push_back('{1'b1, 4'b1111, 1'b0, 1'b0, 4'b0001, 1'b1, 1'b1, 2'd0});
        vecs.push_back('{1'b0, 4'b1111, 1'b1, 1'b1, 4'b0001, 1'b1, 1'b1, 2'd0});
        vecs.push_back('{1'b0, 4'b1111, 1'b1, 1'b1, 4'b0010, 1'b1, 1'b1, 2'd1});
        vecs.push_back('{1'b0, 4'b1111, 1'b1, 1'b1, 4'b0100, 1'b1, 1'b1, 2'd2});
        vecs.push_back('{1'b0, 4'b1111, 1'b1, 1'b1, 4'b1000, 1'b1, 1'b1, 2'd3});
        vecs.push_back('{1'b0, 4'b1111, 1'b1, 1'b1, 4'b0001, 1'b1, 1'b1, 2'd0});
        vecs.push_back('{1'b1, 4'b0011, 1'b0, 1'b0, 4'b0001, 1'b1, 1'b1, 2'd0});
        vecs.push_back('{1'b0, 4'b0011, 1'b1, 1'b0, 4'b0001, 1'b1, 1'b1, 2'd0});
        vecs.push_back('{1'b0, 4'b0011, 1'b1, 1'b0, 4'b0001, 1'b1, 1'b1, 2'd0});
        vecs.push_back('{1'b0, 4'b0011, 1'b1, 1'b0, 4'b0001, 1'b1, 1'b1, 2'd0});
        vecs.push_back('{1'b0, 4'b0011, 1'b1, 1'b1, 4'b0001, 1'b1, 1'b1, 2'd0});
        vecs.push_back('{1'b0, 4'b0011, 1'b0, 1'b0, 4'b0010, 1'b1, 1'b1, 2'd1});
        vecs.push_back('{1'b0, 4'b0100, 1'b1, 1'b0, 4'b0100, 1'b1, 1'b1, 2'd2});
        vecs.push_back('{1'b0, 4'b1001, 1'b0, 1'b0, 4'b0100, 1'b0, 1'b0, 2'd0});
        vecs.push_back('{1'b0, 4'b1001, 1'b1, 1'b1, 4'b0100, 1'b0, 1'b0, 2'd0});
        vecs.push_back('{1'b0, 4'b1101, 1'b1, 1'b1, 4'b0100, 1'b1, 1'b1, 2'd2});
        vecs.push_back('{1'b0, 4'b1101, 1'b0, 1'b0, 4'b1000, 1'b1, 1'b1, 2'd3});
        vecs.push_back('{1'b0, 4'b0011, 1'b0, 1'b0, 4'b0001, 1'b1, 1'b1, 2'd0});
        vecs.push_back('{1'b0, 4'b0010, 1'b0, 1'b1, 4'b0010, 1'b1, 1'b1, 2'd1});
        vecs.push_back('{1'b0, 4'b0000, 1'b1, 1'b1, 4'b0000, 1'b0, 1'b1, 2'd0});
        vecs.push_back('{1'b0, 4'b1001, 1'b1, 1'b0, 4'b1000, 1'b1, 1'b1, 2'd3});
        vecs.push_back('{1'b0, 4'b1001, 1'b0, 1'b0, 4'b1000, 1'b1, 1'b1, 2'd3});
        vecs.push_back('{1'b1, 4'b1001, 1'b0, 1'b0, 4'b0001, 1'b1, 1'b1, 2'd0});
        vecs.push_back('{1'b0, 4'b1001, 1'b0, 1'b0, 4'b0001, 1'b1, 1'b1, 2'd0});

        @(negedge clk);
        #1;
        check("rst_b", grant_b, 4'b0000, valid_b, 1'b0, idx_b, 2'd0, 1'b1);
        check("rst_c", {1'b0, grant_c}, 4'b0000, valid_c, 1'b0, idx_c, 2'd0, 1'b1);
        @(negedge clk);

        // Instance A: table-driven directed vectors
        for (int i = 0; i < vecs.size(); i++) begin
            rstn_a = ~vecs[i].rst;
            req_a  = vecs[i].req;
            rdy_a  = vecs[i].rdy;
            lst_a  = vecs[i].lst;
            #1;
            check($sformatf("vecA[%0d]", i), grant_a, vecs[i].g, valid_a, vecs[i].v,
                  idx_a, vecs[i].idx, vecs[i].ci);
            @(negedge clk);
        end

        // Instance B: fixed priority never rotates; lock still honoured
        rstn_b = 1'b1;
        for (int i = 0; i < 4; i++) begin
            step_b($sformatf("fixed_rep[%0d]", i), 4'b1100, 1'b1, 1'b1, 4'b0100, 1'b1, 1'b1, 2'd2);
        end
        step_b("fixed_lock",   4'b1100, 1'b1, 1'b0, 4'b0100, 1'b1, 1'b1, 2'd2);
        step_b("fixed_held",   4'b1000, 1'b0, 1'b0, 4'b0100, 1'b0, 1'b0, 2'd0);
        step_b("fixed_end",    4'b1100, 1'b1, 1'b1, 4'b0100, 1'b1, 1'b1, 2'd2);
        step_b("fixed_lowest", 4'b1010, 1'b0, 1'b0, 4'b0010, 1'b1, 1'b1, 2'd1);

        // Instance C: random stress against a reference model
        rstn_c   = 1'b1;
        m_ptr    = 2;
        m_lk     = 0;
        m_locked = 1'b0;
        for (int n = 0; n < 300; n++) begin
            req_c = 3'($urandom_range(0, 7));
            rdy_c = ($urandom_range(0, 3) != 0);
            lst_c = 1'($urandom_range(0, 1));
            #1;
            if (!m_locked) begin
                eg = 3'b000;
                ei = 0;
                for (int k = 1; k <= 3; k++) begin
                    j = (m_ptr + k) % 3;
                    if (eg == 3'b000 && req_c[j]) begin
                        eg = 3'b001 << j;
                        ei = j;
                    end
                end
                ev = |req_c;
            end else begin
                eg = 3'b001 << m_lk;
                ev = req_c[m_lk];
                ei = m_lk;
            end
            check($sformatf("stress[%0d]", n), {1'b0, grant_c}, {1'b0, eg}, valid_c, ev,
                  idx_c, 2'(ei), ev);
            checks++;
            if ($countones(grant_c) > 1 || idx_c >= 2'd3) begin
                errors++;
                $display("FAIL stress_onehot[%0d]: grant=%b idx=%0d, required one-hot grant and idx<3",
                         n, grant_c, idx_c);
            end
            if (ev && rdy_c) begin
                if (lst_c) begin
                    m_ptr    = ei;
                    m_locked = 1'b0;
                end else begin
                    m_locked = 1'b1;
                    m_lk     = ei;
                end
            end
            @(negedge clk);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
